// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions: opcode encodings and one-hot enable bit positions.
// Used by the issue block and by the opcode decoder.
package alu_ctrl_pkg;
    localparam int EN_W  = 6;
    localparam int OPC_W = 5;

    localparam int EN_ADD = 0;
    localparam int EN_SUB = 1;
    localparam int EN_AND = 2;
    localparam int EN_OR  = 3;
    localparam int EN_SLL = 4;
    localparam int EN_SRA = 5;

    localparam logic [OPC_W-1:0] OP_ADD = 5'b00000;
    localparam logic [OPC_W-1:0] OP_SUB = 5'b00001;
    localparam logic [OPC_W-1:0] OP_AND = 5'b00010;
    localparam logic [OPC_W-1:0] OP_OR  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SLL = 5'b00100;
    localparam logic [OPC_W-1:0] OP_SRA = 5'b00101;
endpackage

// File: rtl/op_encode.sv
// One-hot operation enable to 5-bit ALU opcode; legal is low for zero or multi-hot input.
module op_encode
    import alu_ctrl_pkg::*;
(
    input  logic [EN_W-1:0]  en,
    output logic [OPC_W-1:0] opcode,
    output logic             legal
);
    always_comb begin
        opcode = OP_ADD;
        legal  = 1'b1;
        case (en)
            EN_W'(1 << EN_ADD): opcode = OP_ADD;
            EN_W'(1 << EN_SUB): opcode = OP_SUB;
            EN_W'(1 << EN_AND): opcode = OP_AND;
            EN_W'(1 << EN_OR):  opcode = OP_OR;
            EN_W'(1 << EN_SLL): opcode = OP_SLL;
            EN_W'(1 << EN_SRA): opcode = OP_SRA;
            default:            legal  = 1'b0;
        endcase
    end
endmodule

// File: rtl/alu_op_issue.sv
// ALU issue stage: encodes one-hot requests, buffers up to two ops and hands them
// to the ALU over valid/ready; drops and flags illegal requests, counts issued ops.
module alu_op_issue
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EN_W-1:0]   in_en,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [4:0]        in_shamt,
    output logic              alu_valid,
    input  logic              alu_ready,
    output logic [OPC_W-1:0]  ctrl_ALUopcode,
    output logic [DATA_W-1:0] data_operandA,
    output logic [DATA_W-1:0] data_operandB,
    output logic [4:0]        ctrl_shiftamt,
    output logic              err_illegal,
    output logic [CNT_W-1:0]  issue_count
);
    typedef struct packed {
        logic [OPC_W-1:0]  opc;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [4:0]        shamt;
    } entry_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;

    occ_t             occ_q, occ_d;
    entry_t           head_q, head_d, tail_q, tail_d, new_e;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OPC_W-1:0] enc_opc;
    logic             enc_legal;
    logic             accept, push, pop;

    op_encode u_enc (
        .en     (in_en),
        .opcode (enc_opc),
        .legal  (enc_legal)
    );

    // Ready decodes only the occupancy flops; gated low while reset is held.
    assign in_ready  = reset_n && (occ_q != FULL);
    assign alu_valid = (occ_q != EMPTY);
    assign accept    = in_valid && in_ready;
    assign push      = accept && enc_legal;
    assign pop       = alu_valid && alu_ready;
    assign new_e     = '{opc: enc_opc, a: in_a, b: in_b, shamt: in_shamt};

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case (occ_q)
            EMPTY: if (push) begin
                head_d = new_e;
                occ_d  = ONE;
            end
            ONE: begin
                if (push && pop) begin
                    head_d = new_e;
                end else if (push) begin
                    tail_d = new_e;
                    occ_d  = FULL;
                end else if (pop) begin
                    occ_d  = EMPTY;
                end
            end
            FULL: if (pop) begin
                head_d = tail_q;
                occ_d  = ONE;
            end
            default: occ_d = EMPTY;
        endcase
        err_d = accept && !enc_legal;
        cnt_d = cnt_q + CNT_W'(pop);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            occ_q  <= EMPTY;
            head_q <= '0;
            tail_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ctrl_ALUopcode = head_q.opc;
    assign data_operandA  = head_q.a;
    assign data_operandB  = head_q.b;
    assign ctrl_shiftamt  = head_q.shamt;
    assign err_illegal    = err_q;
    assign issue_count    = cnt_q;
endmodule
